// File: rtl/exec_stage_pipe.sv
// Registered Y86-64 execute stage: ALU, branch/cmov condition, CC register, valid/ready output register.
// Define EXEC_MUL_EN to add an iterative signed multiply (OPq ifun 4).
module exec_stage_pipe #(
    parameter int          WIDTH      = 64,
    parameter int          STACK_STEP = 8,
    parameter logic [2:0]  CC_RESET   = 3'b001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_icode,
    input  logic [3:0]       in_ifun,
    input  logic [WIDTH-1:0] in_valA,
    input  logic [WIDTH-1:0] in_valB,
    input  logic [WIDTH-1:0] in_valC,
    input  logic [3:0]       in_dstE,
    input  logic [3:0]       in_dstM,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_icode,
    output logic             out_cnd,
    output logic [WIDTH-1:0] out_valE,
    output logic [WIDTH-1:0] out_valA,
    output logic [3:0]       out_dstE,
    output logic [3:0]       out_dstM,
    output logic [2:0]       cc
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

    logic             busy;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_valE;
    logic [WIDTH-1:0] mul_valA;
    logic [3:0]       mul_dstE;
    logic [3:0]       mul_dstM;

    logic [WIDTH-1:0] sum_ab;
    logic [WIDTH-1:0] diff_ab;
    logic [WIDTH-1:0] alu_valE;
    logic             alu_of;
    logic             cc_we;
    logic             cond_true;
    logic             cnd;

    assign in_ready = !busy && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign sum_ab   = in_valB + in_valA;
    assign diff_ab  = in_valB - in_valA;

    always_comb begin
        alu_valE = '0;
        alu_of   = 1'b0;
        cc_we    = 1'b0;
        case (in_icode)
            4'h2:       alu_valE = in_valA;
            4'h3:       alu_valE = in_valC;
            4'h4, 4'h5: alu_valE = in_valB + in_valC;
            4'h6: begin
                case (in_ifun)
                    4'h0: begin
                        alu_valE = sum_ab;
                        alu_of   = (in_valA[WIDTH-1] == in_valB[WIDTH-1]) &&
                                   (sum_ab[WIDTH-1] != in_valB[WIDTH-1]);
                        cc_we    = 1'b1;
                    end
                    4'h1: begin
                        alu_valE = diff_ab;
                        alu_of   = (in_valB[WIDTH-1] != in_valA[WIDTH-1]) &&
                                   (diff_ab[WIDTH-1] != in_valB[WIDTH-1]);
                        cc_we    = 1'b1;
                    end
                    4'h2: begin
                        alu_valE = in_valB & in_valA;
                        cc_we    = 1'b1;
                    end
                    4'h3: begin
                        alu_valE = in_valB ^ in_valA;
                        cc_we    = 1'b1;
                    end
                    default: ;
                endcase
            end
            4'h8, 4'hA: alu_valE = in_valB - STEP;
            4'h9, 4'hB: alu_valE = in_valB + STEP;
            default: ;
        endcase
    end

    // Condition reads the CC value held before this edge's write.
    always_comb begin
        cond_true = 1'b0;
        case (in_ifun)
            4'h0: cond_true = 1'b1;
            4'h1: cond_true = (cc[1] ^ cc[2]) | cc[0];
            4'h2: cond_true = cc[1] ^ cc[2];
            4'h3: cond_true = cc[0];
            4'h4: cond_true = !cc[0];
            4'h5: cond_true = !(cc[1] ^ cc[2]);
            4'h6: cond_true = !(cc[1] ^ cc[2]) && !cc[0];
            default: ;
        endcase
        cnd = (in_icode == 4'h2 || in_icode == 4'h7) ? cond_true : 1'b0;
    end

`ifdef EXEC_MUL_EN
    typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;
    localparam int CW = $clog2(WIDTH) + 1;

    mul_state_t       state;
    mul_state_t       next_state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;

    assign mul_start = accept && in_icode == 4'h6 && in_ifun == 4'h4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MUL_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            MUL_IDLE: if (mul_start) next_state = MUL_BUSY;
            MUL_BUSY: begin
                if (flush)                             next_state = MUL_IDLE;
                else if (count == CW'(WIDTH - 1))      next_state = MUL_DONE;
            end
            MUL_DONE: next_state = MUL_IDLE;
            default:  next_state = MUL_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != MUL_IDLE);
        mul_done = (state == MUL_DONE) && !flush;
    end

    // Shift-add over all WIDTH bits yields the low WIDTH bits of the signed product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            count    <= '0;
            mul_valA <= '0;
            mul_dstE <= 4'hF;
            mul_dstM <= 4'hF;
        end else if (mul_start) begin
            acc      <= '0;
            mcand    <= in_valB;
            mplier   <= in_valA;
            count    <= '0;
            mul_valA <= in_valA;
            mul_dstE <= in_dstE;
            mul_dstM <= in_dstM;
        end else if (state == MUL_BUSY) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
        end
    end

    assign mul_valE = acc;
`else
    assign busy      = 1'b0;
    assign mul_start = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_valE  = '0;
    assign mul_valA  = '0;
    assign mul_dstE  = 4'hF;
    assign mul_dstM  = 4'hF;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_icode <= 4'h0;
            out_cnd   <= 1'b0;
            out_valE  <= '0;
            out_valA  <= '0;
            out_dstE  <= 4'hF;
            out_dstM  <= 4'hF;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_dstE  <= 4'hF;
            out_dstM  <= 4'hF;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            out_icode <= 4'h6;
            out_cnd   <= 1'b0;
            out_valE  <= mul_valE;
            out_valA  <= mul_valA;
            out_dstE  <= mul_dstE;
            out_dstM  <= mul_dstM;
        end else if (accept && !mul_start) begin
            out_valid <= 1'b1;
            out_icode <= in_icode;
            out_cnd   <= cnd;
            out_valE  <= alu_valE;
            out_valA  <= in_valA;
            out_dstE  <= (in_icode == 4'h2 && !cnd) ? 4'hF : in_dstE;
            out_dstM  <= in_dstM;
        end else if (mul_start || (out_valid && out_ready)) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cc <= CC_RESET;
        else if (mul_done)
            cc <= {1'b0, mul_valE[WIDTH-1], (mul_valE == '0)};
        else if (accept && cc_we)
            cc <= {alu_of, alu_valE[WIDTH-1], (alu_valE == '0)};
    end

endmodule

// File: tb/tb_exec_stage_pipe.sv
// Directed testbench for exec_stage_pipe: vector table plus handshake, flush and multiply sequences.
module tb_exec_stage_pipe;

    localparam int WIDTH = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_icode;
    logic [3:0]       in_ifun;
    logic [WIDTH-1:0] in_valA;
    logic [WIDTH-1:0] in_valB;
    logic [WIDTH-1:0] in_valC;
    logic [3:0]       in_dstE;
    logic [3:0]       in_dstM;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_icode;
    logic             out_cnd;
    logic [WIDTH-1:0] out_valE;
    logic [WIDTH-1:0] out_valA;
    logic [3:0]       out_dstE;
    logic [3:0]       out_dstM;
    logic [2:0]       cc;

    int checks = 0;
    int errors = 0;

    exec_stage_pipe #(.WIDTH(WIDTH), .STACK_STEP(8), .CC_RESET(3'b001)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_ifun(in_ifun),
        .in_valA(in_valA), .in_valB(in_valB), .in_valC(in_valC),
        .in_dstE(in_dstE), .in_dstM(in_dstM),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_icode(out_icode), .out_cnd(out_cnd),
        .out_valE(out_valE), .out_valA(out_valA),
        .out_dstE(out_dstE), .out_dstM(out_dstM),
        .cc(cc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [63:0] valC;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [63:0] exp_valE;
        logic        exp_cnd;
        logic [3:0]  exp_dstE;
        logic [2:0]  exp_cc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(string name, logic [3:0] icode, logic [3:0] ifun,
                                   logic [63:0] valA, logic [63:0] valB, logic [63:0] valC,
                                   logic [3:0] dstE, logic [63:0] exp_valE, logic exp_cnd,
                                   logic [3:0] exp_dstE, logic [2:0] exp_cc);
        vec_t v;
        v.name = name; v.icode = icode; v.ifun = ifun;
        v.valA = valA; v.valB = valB; v.valC = valC;
        v.dstE = dstE; v.dstM = 4'hE;
        v.exp_valE = exp_valE; v.exp_cnd = exp_cnd;
        v.exp_dstE = exp_dstE; v.exp_cc = exp_cc;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one instruction for a single accept edge; outputs are sampled 1 time unit later.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        in_valid = 1'b1;
        in_icode = v.icode;
        in_ifun  = v.ifun;
        in_valA  = v.valA;
        in_valB  = v.valB;
        in_valC  = v.valC;
        in_dstE  = v.dstE;
        in_dstM  = v.dstM;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input vec_t v);
        check({v.name, ".valid"}, 64'(out_valid), 64'd1);
        check({v.name, ".icode"}, 64'(out_icode), 64'(v.icode));
        check({v.name, ".valE"},  out_valE,       v.exp_valE);
        check({v.name, ".valA"},  out_valA,       v.valA);
        check({v.name, ".cnd"},   64'(out_cnd),   64'(v.exp_cnd));
        check({v.name, ".dstE"},  64'(out_dstE),  64'(v.exp_dstE));
        check({v.name, ".dstM"},  64'(out_dstM),  64'(v.dstM));
        check({v.name, ".cc"},    64'(cc),        64'(v.exp_cc));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t v;
        int   busy_cnt;
        bit   seen_valid;

        vecs.push_back(mkVec("sub_eq",    4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h3, 64'd0, 1'b0, 4'h3, 3'b001));
        vecs.push_back(mkVec("add_ovf",   4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h3,
                             64'h8000_0000_0000_0000, 1'b0, 4'h3, 3'b110));
        vecs.push_back(mkVec("jl_110",    4'h7, 4'h2, 64'd0, 64'd0, 64'h40, 4'hF, 64'd0, 1'b0, 4'hF, 3'b110));
        vecs.push_back(mkVec("sub_neg",   4'h6, 4'h1, 64'd2, 64'd1, 64'd0, 4'h3,
                             64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'h3, 3'b010));
        vecs.push_back(mkVec("cmovl",     4'h2, 4'h2, 64'h1234, 64'd0, 64'd0, 4'h5, 64'h1234, 1'b1, 4'h5, 3'b010));
        vecs.push_back(mkVec("cmove",     4'h2, 4'h3, 64'h55, 64'd0, 64'd0, 4'h6, 64'h55, 1'b0, 4'hF, 3'b010));
        vecs.push_back(mkVec("jmp",       4'h7, 4'h0, 64'd0, 64'd0, 64'h80, 4'hF, 64'd0, 1'b1, 4'hF, 3'b010));
        vecs.push_back(mkVec("jge_010",   4'h7, 4'h5, 64'd0, 64'd0, 64'h80, 4'hF, 64'd0, 1'b0, 4'hF, 3'b010));
        vecs.push_back(mkVec("jne_010",   4'h7, 4'h4, 64'd0, 64'd0, 64'h80, 4'hF, 64'd0, 1'b1, 4'hF, 3'b010));
        vecs.push_back(mkVec("irmov",     4'h3, 4'h0, 64'd0, 64'd0, 64'hABCD, 4'h2, 64'hABCD, 1'b0, 4'h2, 3'b010));
        vecs.push_back(mkVec("rmmov",     4'h4, 4'h0, 64'h9, 64'h100, 64'h20, 4'hF, 64'h120, 1'b0, 4'hF, 3'b010));
        vecs.push_back(mkVec("mrmov",     4'h5, 4'h0, 64'h0, 64'h200, 64'hFFFF_FFFF_FFFF_FFF8, 4'hF,
                             64'h1F8, 1'b0, 4'hF, 3'b010));
        vecs.push_back(mkVec("push",      4'hA, 4'h0, 64'h7, 64'h100, 64'd0, 4'h4, 64'hF8, 1'b0, 4'h4, 3'b010));
        vecs.push_back(mkVec("call_wrap", 4'h8, 4'h0, 64'h0, 64'h0, 64'h300, 4'h4,
                             64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 4'h4, 3'b010));
        vecs.push_back(mkVec("pop",       4'hB, 4'h0, 64'h100, 64'h100, 64'd0, 4'h4, 64'h108, 1'b0, 4'h4, 3'b010));
        vecs.push_back(mkVec("ret",       4'h9, 4'h0, 64'h200, 64'h200, 64'd0, 4'h4, 64'h208, 1'b0, 4'h4, 3'b010));
        vecs.push_back(mkVec("and",       4'h6, 4'h2, 64'h3C, 64'hF0, 64'd0, 4'h1, 64'h30, 1'b0, 4'h1, 3'b000));
        vecs.push_back(mkVec("cmovle_0",  4'h2, 4'h1, 64'h99, 64'd0, 64'd0, 4'h7, 64'h99, 1'b0, 4'hF, 3'b000));
        vecs.push_back(mkVec("xor_zero",  4'h6, 4'h3, 64'hA, 64'hA, 64'd0, 4'h1, 64'd0, 1'b0, 4'h1, 3'b001));
        vecs.push_back(mkVec("jle_zf",    4'h7, 4'h1, 64'd0, 64'd0, 64'h10, 4'hF, 64'd0, 1'b1, 4'hF, 3'b001));
        vecs.push_back(mkVec("opq_bad",   4'h6, 4'h7, 64'd1, 64'd1, 64'd0, 4'h1, 64'd0, 1'b0, 4'h1, 3'b001));
        vecs.push_back(mkVec("nop",       4'h1, 4'h0, 64'd7, 64'd9, 64'd3, 4'hF, 64'd0, 1'b0, 4'hF, 3'b001));
        vecs.push_back(mkVec("sub_ovf",   4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 4'h2,
                             64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 4'h2, 3'b100));
        vecs.push_back(mkVec("jl_100",    4'h7, 4'h2, 64'd0, 64'd0, 64'h10, 4'hF, 64'd0, 1'b1, 4'hF, 3'b100));
        vecs.push_back(mkVec("jg_100",    4'h7, 4'h6, 64'd0, 64'd0, 64'h10, 4'hF, 64'd0, 1'b0, 4'hF, 3'b100));
        vecs.push_back(mkVec("cmovge",    4'h2, 4'h5, 64'h42, 64'd0, 64'd0, 4'h7, 64'h42, 1'b0, 4'hF, 3'b100));
        vecs.push_back(mkVec("halt",      4'h0, 4'h0, 64'd1, 64'd5, 64'd6, 4'h3, 64'd0, 1'b0, 4'h3, 3'b100));

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_icode = '0; in_ifun = '0; in_valA = '0; in_valB = '0; in_valC = '0;
        in_dstE = '0; in_dstM = '0;
        #12;
        check("reset.cc",       64'(cc),        64'(3'b001));
        check("reset.valid",    64'(out_valid), 64'd0);
        check("reset.dstE",     64'(out_dstE),  64'hF);
        check("reset.dstM",     64'(out_dstM),  64'hF);
        check("reset.valE",     out_valE,       64'd0);
        check("reset.in_ready", 64'(in_ready),  64'd1);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        @(posedge clk); #1;
        check("drain.valid", 64'(out_valid), 64'd0);

        // Backpressure: a result stalled by out_ready=0 must hold while the next instruction waits.
        out_ready = 1'b0;
        v = mkVec("irmov77", 4'h3, 4'h0, 64'd0, 64'd0, 64'h77, 4'h1, 64'h77, 1'b0, 4'h1, 3'b100);
        applyStimulus(v);
        checkOutput(v);
        @(negedge clk);
        in_valid = 1'b1; in_icode = 4'h3; in_ifun = 4'h0; in_valC = 64'h88; in_dstE = 4'h2;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("stall.in_ready", 64'(in_ready),  64'd0);
            check("stall.valid",    64'(out_valid), 64'd1);
            check("stall.valE",     out_valE,       64'h77);
            check("stall.dstE",     64'(out_dstE),  64'h1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("release.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("release.valid", 64'(out_valid), 64'd1);
        check("release.valE",  out_valE,       64'h88);
        check("release.dstE",  64'(out_dstE),  64'h2);

        // Flush in the same cycle as an OPq: no result, no CC update.
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_icode = 4'h6; in_ifun = 4'h0;
        in_valA = 64'd1; in_valB = 64'd1; in_dstE = 4'h3; in_dstM = 4'h5;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush.valid", 64'(out_valid), 64'd0);
        check("flush.cc",    64'(cc),        64'(3'b100));
        check("flush.dstE",  64'(out_dstE),  64'hF);
        check("flush.dstM",  64'(out_dstM),  64'hF);
        v = mkVec("push_after_flush", 4'hA, 4'h0, 64'h3, 64'h100, 64'd0, 4'h4, 64'hF8, 1'b0, 4'h4, 3'b100);
        applyStimulus(v);
        checkOutput(v);

`ifdef EXEC_MUL_EN
        // Multiply -3 * 7: stage stalls while the shift-add runs, then reports -21 with SF set.
        @(negedge clk);
        in_valid = 1'b1; in_icode = 4'h6; in_ifun = 4'h4;
        in_valA = 64'd7; in_valB = 64'hFFFF_FFFF_FFFF_FFFD; in_dstE = 4'h9; in_dstM = 4'hF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        busy_cnt = 0;
        seen_valid = 1'b0;
        for (int k = 0; k < 4 * WIDTH && !seen_valid; k++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
            else if (!in_ready) busy_cnt++;
        end
        check("mul.done",     64'(seen_valid), 64'd1);
        check("mul.busy_min", 64'(busy_cnt >= WIDTH),     64'd1);
        check("mul.busy_max", 64'(busy_cnt <= WIDTH + 1), 64'd1);
        check("mul.valE",     out_valE,        64'hFFFF_FFFF_FFFF_FFEB);
        check("mul.icode",    64'(out_icode),  64'h6);
        check("mul.dstE",     64'(out_dstE),   64'h9);
        check("mul.cc",       64'(cc),         64'(3'b010));

        v = mkVec("xor_cc", 4'h6, 4'h3, 64'h5, 64'h5, 64'd0, 4'h1, 64'd0, 1'b0, 4'h1, 3'b001);
        applyStimulus(v);
        checkOutput(v);

        @(negedge clk);
        in_valid = 1'b1; in_icode = 4'h6; in_ifun = 4'h4;
        in_valA = 64'd7; in_valB = 64'hFFFF_FFFF_FFFF_FFFD; in_dstE = 4'h9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        seen_valid = 1'b0;
        for (int k = 0; k < WIDTH + 8; k++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("mulflush.no_result", 64'(seen_valid), 64'd0);
        check("mulflush.cc",        64'(cc),         64'(3'b001));
        check("mulflush.in_ready",  64'(in_ready),   64'd1);
`else
        busy_cnt = 0;
        seen_valid = 1'b0;
        v = mkVec("mul_illegal", 4'h6, 4'h4, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 4'h9,
                  64'd0, 1'b0, 4'h9, 3'b100);
        applyStimulus(v);
        checkOutput(v);
        @(negedge clk);
        check("mul_illegal.in_ready", 64'(in_ready), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
